// File: rtl/hdc_pkg.sv
// Shared HDC constants and controller state encoding for the encoder, search
// and class-vector sequencers.
package hdc_pkg;

    localparam int unsigned NUM_CLASSES = 8;
    localparam int unsigned NUM_FRAMES  = 3;
    localparam int unsigned FRAME_W     = 64;
    localparam int unsigned CID_W       = 3;
    localparam int unsigned FIDX_W      = 2;

    // Common controller states: idle, addresses left to load, last beat pending.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/class_vec_seq.sv
// Class hypervector sequencer: walks the class ROM addresses over all classes
// or a single class and streams each registered frame over valid/ready.
module class_vec_seq #(
    parameter int unsigned NUM_CLASSES = hdc_pkg::NUM_CLASSES,
    parameter int unsigned NUM_FRAMES  = hdc_pkg::NUM_FRAMES,
    parameter int unsigned FRAME_W     = hdc_pkg::FRAME_W,
    parameter int unsigned CID_W       = hdc_pkg::CID_W,
    parameter int unsigned FIDX_W      = hdc_pkg::FIDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               single,
    input  logic [CID_W-1:0]   class_sel,
    input  logic               abort,
    output logic [CID_W-1:0]   rom_frame_id,
    output logic [FIDX_W-1:0]  rom_frame_index,
    input  logic [FRAME_W-1:0] rom_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [FRAME_W-1:0] m_data,
    output logic [CID_W-1:0]   m_class_id,
    output logic [FIDX_W-1:0]  m_frame_idx,
    output logic               m_last_frame,
    output logic               m_last_class,
    output logic               busy,
    output logic               done,
    output logic               err
);
    import hdc_pkg::seq_state_e;
    import hdc_pkg::IDLE;
    import hdc_pkg::RUN;
    import hdc_pkg::DRAIN;

    localparam logic [FIDX_W-1:0] LAST_FIDX = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [CID_W-1:0]  LAST_CLS  = CID_W'(NUM_CLASSES - 1);

    seq_state_e        state;
    logic [CID_W-1:0]  cls;
    logic [CID_W-1:0]  end_cls;
    logic [FIDX_W-1:0] fidx;
    logic              can_load;
    logic              last_addr;
    logic              sel_ok;

    // Output register is free when empty or being drained this cycle.
    assign can_load  = !m_valid || m_ready;
    assign last_addr = (cls == end_cls) && (fidx == LAST_FIDX);
    assign sel_ok    = 32'(class_sel) < NUM_CLASSES;

    // ROM address comes straight from the counters; data returns combinationally.
    assign rom_frame_id    = cls;
    assign rom_frame_index = fidx;

    // Sweep FSM, address counters and registered output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cls          <= '0;
            end_cls      <= '0;
            fidx         <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_class_id   <= '0;
            m_frame_idx  <= '0;
            m_last_frame <= 1'b0;
            m_last_class <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                busy    <= 1'b0;
                m_valid <= 1'b0;
                cls     <= '0;
                end_cls <= '0;
                fidx    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (single && !sel_ok) begin
                                err <= 1'b1;
                            end else begin
                                cls     <= single ? class_sel : '0;
                                end_cls <= single ? class_sel : LAST_CLS;
                                fidx    <= '0;
                                state   <= RUN;
                                busy    <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (can_load) begin
                            m_valid      <= 1'b1;
                            m_data       <= rom_data;
                            m_class_id   <= cls;
                            m_frame_idx  <= fidx;
                            m_last_frame <= (fidx == LAST_FIDX);
                            m_last_class <= last_addr;
                            if (fidx == LAST_FIDX) begin
                                fidx <= '0;
                                cls  <= cls + 1'b1;
                            end else begin
                                fidx <= fidx + 1'b1;
                            end
                            if (last_addr) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (m_valid && m_ready) begin
                            m_valid <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        m_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_class_vec_seq.sv
// Randomized self-checking bench for class_vec_seq with a queue-based beat model.
module tb_class_vec_seq;

    localparam int unsigned NC = 8;
    localparam int unsigned NF = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, single, abort;
    logic [2:0]  class_sel;
    logic [2:0]  rom_frame_id;
    logic [1:0]  rom_frame_index;
    logic [63:0] rom_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic [2:0]  m_class_id;
    logic [1:0]  m_frame_idx;
    logic        m_last_frame, m_last_class, busy, done, err;

    logic        start2, single2;
    logic [2:0]  class_sel2;
    logic [2:0]  rom_frame_id2;
    logic [1:0]  rom_frame_index2;
    logic [63:0] rom_data2;
    logic        m_valid2;
    logic        m_ready2 = 1'b1;
    logic [63:0] m_data2;
    logic [2:0]  m_class_id2;
    logic [1:0]  m_frame_idx2;
    logic        m_last_frame2, m_last_class2, busy2, done2, err2;

    int total = 0;
    int bad = 0;
    int beats = 0;
    int done_cnt = 0;
    int ready_mode = 0;
    bit mon_en = 1'b0;
    logic exp_done = 1'b0;
    logic mon_nxt;

    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  c;
        logic [1:0]  f;
        logic        lf;
        logic        lc;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    // Stand-in class ROM contents: distinct word per (class, frame).
    function automatic logic [63:0] rom_fn(input logic [2:0] c, input logic [1:0] f);
        rom_fn = (64'h9E37_79B9_7F4A_7C15 * (64'(c) * 64'd4 + 64'(f) + 64'd1)) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    assign rom_data  = rom_fn(rom_frame_id, rom_frame_index);
    assign rom_data2 = rom_fn(rom_frame_id2, rom_frame_index2);

    class_vec_seq dut (
        .clk(clk), .rst(rst), .start(start), .single(single), .class_sel(class_sel),
        .abort(abort), .rom_frame_id(rom_frame_id), .rom_frame_index(rom_frame_index),
        .rom_data(rom_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_class_id(m_class_id), .m_frame_idx(m_frame_idx), .m_last_frame(m_last_frame),
        .m_last_class(m_last_class), .busy(busy), .done(done), .err(err)
    );

    class_vec_seq #(.NUM_CLASSES(6)) dut6 (
        .clk(clk), .rst(rst), .start(start2), .single(single2), .class_sel(class_sel2),
        .abort(1'b0), .rom_frame_id(rom_frame_id2), .rom_frame_index(rom_frame_index2),
        .rom_data(rom_data2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
        .m_class_id(m_class_id2), .m_frame_idx(m_frame_idx2), .m_last_frame(m_last_frame2),
        .m_last_class(m_last_class2), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Expected beats of a sweep, straight from the class/frame walk order.
    task automatic push_sweep(input logic sgl, input int sel);
        int first;
        int last;
        beat_t b;
        first = sgl ? sel : 0;
        last  = sgl ? sel : int'(NC) - 1;
        for (int c = first; c <= last; c++) begin
            for (int f = 0; f < int'(NF); f++) begin
                b.d  = rom_fn(3'(c), 2'(f));
                b.c  = 3'(c);
                b.f  = 2'(f);
                b.lf = (f == int'(NF) - 1);
                b.lc = (c == last) && (f == int'(NF) - 1);
                q.push_back(b);
            end
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at the next posedge+1.
    task automatic start_sweep(input logic sgl, input logic [2:0] sel);
        start     = 1'b1;
        single    = sgl;
        class_sel = sel;
        push_sweep(sgl, int'(sel));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit pulses);
        int n0;
        int n;
        n0 = done_cnt;
        n  = 0;
        while (done_cnt == n0 && n < budget) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (pulses && busy && ($urandom_range(0, 3) == 0)) begin
                start     = 1'b1;
                single    = 1'($urandom_range(0, 1));
                class_sel = 3'($urandom_range(0, 7));
            end
        end
        start = 1'b0;
        check("done_timeout", 64'(done_cnt != n0), 64'd1);
    endtask

    // Downstream ready pattern, applied after the stimulus of the same cycle.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor: every valid cycle must show the model's head beat.
    always @(negedge clk) begin
        if (mon_en) begin
            check("done", 64'(done), 64'(exp_done));
            check("err", 64'(err), 64'd0);
            if (done === 1'b1) done_cnt++;
            mon_nxt = 1'b0;
            if (m_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 64'd1, 64'd0);
                end else begin
                    check("data", m_data, q[0].d);
                    check("tags", 64'({m_class_id, m_frame_idx, m_last_frame, m_last_class}),
                          64'({q[0].c, q[0].f, q[0].lf, q[0].lc}));
                    if (m_ready) begin
                        mon_nxt = q[0].lc && !abort;
                        void'(q.pop_front());
                        beats++;
                    end
                end
            end
            exp_done = mon_nxt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int b0;
        bit found;

        rst = 1'b1; start = 1'b1; single = 1'b0; class_sel = '0; abort = 1'b0;
        start2 = 1'b0; single2 = 1'b0; class_sel2 = '0;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        check("rst_rom_addr", 64'({rom_frame_id, rom_frame_index}), 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_tags", 64'({m_class_id, m_frame_idx, m_last_frame, m_last_class}), 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 64'({busy, m_valid}), 64'd0);
        mon_en = 1'b1;

        // Full sweep at full throughput: latency and end-of-sweep timing.
        ready_mode = 1;
        @(posedge clk); #1;
        b0 = beats;
        start_sweep(1'b0, 3'd0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_latency", 64'({busy, m_valid}), 64'b10);
            if (n == 2) check("valid_latency", 64'(m_valid), 64'd1);
        end
        check("sweep_cycles", 64'(n), 64'd26);
        check("sweep_beats", 64'(beats - b0), 64'd24);
        check("sweep_drained", 64'(q.size()), 64'd0);

        // Single class under random backpressure.
        ready_mode = 2;
        @(posedge clk); #1;
        b0 = beats;
        start_sweep(1'b1, 3'd5);
        wait_done(200, 1'b0);
        check("single_beats", 64'(beats - b0), 64'd3);
        check("single_drained", 64'(q.size()), 64'd0);

        // Random sweeps with ignored start pulses while busy.
        for (int i = 0; i < 6; i++) begin
            ready_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
            @(posedge clk); #1;
            start_sweep(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            wait_done(400, 1'b1);
            check("rand_drained", 64'(q.size()), 64'd0);
        end

        // Abort while beat (2,1) is stalled.
        ready_mode = 2;
        @(posedge clk); #1;
        start_sweep(1'b0, 3'd0);
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (m_valid && q.size() > 0 && q[0].c == 3'd2 && q[0].f == 2'd1) found = 1'b1;
        end
        check("abort_reached", 64'(found), 64'd1);
        ready_mode = 0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        @(negedge clk);
        check("abort_idle", 64'({busy, m_valid}), 64'd0);
        check("abort_counters", 64'({rom_frame_id, rom_frame_index}), 64'd0);
        ready_mode = 1;
        @(posedge clk); #1;
        start_sweep(1'b0, 3'd0);
        wait_done(100, 1'b0);
        check("post_abort_drained", 64'(q.size()), 64'd0);

        // Abort at a random point with random ready; a same-cycle accept counts.
        ready_mode = 2;
        @(posedge clk); #1;
        start_sweep(1'b0, 3'd0);
        repeat ($urandom_range(3, 20)) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        @(negedge clk);
        check("abort2_idle", 64'({busy, m_valid}), 64'd0);

        // Start accepted in the done cycle.
        ready_mode = 1;
        @(posedge clk); #1;
        start_sweep(1'b0, 3'd0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        start_sweep(1'b1, 3'd3);
        @(negedge clk);
        check("b2b_busy", 64'({busy, m_valid}), 64'b10);
        @(negedge clk);
        check("b2b_first_beat", 64'(m_valid), 64'd1);
        @(posedge clk); #1;
        wait_done(100, 1'b1);
        check("b2b_drained", 64'(q.size()), 64'd0);

        // Six-class build: out-of-range selections raise err and stay idle.
        for (int s = 6; s <= 7; s++) begin
            @(posedge clk); #1;
            start2 = 1'b1; single2 = 1'b1; class_sel2 = 3'(s);
            @(posedge clk); #1;
            start2 = 1'b0;
            @(negedge clk);
            check("err_pulse", 64'({err2, busy2, m_valid2}), 64'b100);
            @(negedge clk);
            check("err_cleared", 64'({err2, busy2, m_valid2}), 64'b000);
        end
        @(posedge clk); #1;
        start2 = 1'b1; single2 = 1'b1; class_sel2 = 3'd5;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        k = 0;
        while (done2 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            if (n == 1) check("nc6_busy", 64'({busy2, err2}), 64'b10);
            if (m_valid2 === 1'b1) begin
                k++;
                check("nc6_data", m_data2, rom_fn(3'd5, 2'(k - 1)));
            end
        end
        check("nc6_beats", 64'(k), 64'd3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
